// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 byte receiver: receiver states, the
// oversample factor and the baud divider calculation.
package rs232_pkg;

    localparam int OS_FACTOR = 16;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OS_FACTOR);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, re-phased by restart.
// The first tick follows restart by one clock so sampling stays centred despite sync latency.
module rs232_baud_tick
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == CNT_W'(DIV - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/rs232_byte_rx.sv
// RS-232 byte receiver: 16x oversampling, 2-of-3 majority per bit, optional
// parity, frame-error detection and break hold-off.
module rs232_byte_rx
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    input  logic       i_rx_pin,
    output logic [7:0] o_rx_dat,
    output logic       o_rx_over,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err,
    output logic       o_rx_busy
);

    rx_state_t         state, state_nxt;
    logic              sync_p0, sync_p1, rx_p2;
    logic [2:0]        settle;
    logic [3:0]        os_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift_p;
    logic [1:0]        samp;
    logic              par_err;
    logic              tick, restart, decide, bit_val;
    logic              load_byte, frame_bad;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Edge detection waits until rx_p2 holds a real line sample after reset.
    assign restart = (state == IDLE) && settle[2] && rx_p2 && !sync_p1;
    assign decide  = tick && (os_cnt == 4'd8);
    assign bit_val = maj3(samp[1], samp[0], sync_p1);

    rs232_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        load_byte = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE:   if (restart) state_nxt = START;
            START:  if (decide) state_nxt = bit_val ? IDLE : DATA;
            DATA:   if (decide && (bit_idx == 3'd7))
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (decide) state_nxt = STOP;
            STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        load_byte = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK:  if (sync_p1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sync_p0         <= 1'b1;
            sync_p1         <= 1'b1;
            rx_p2           <= 1'b1;
            settle          <= '0;
            os_cnt          <= '0;
            bit_idx         <= '0;
            par_err         <= 1'b0;
            o_rx_dat        <= '0;
            o_rx_over       <= 1'b0;
            o_rx_frame_err  <= 1'b0;
            o_rx_parity_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            sync_p0 <= i_rx_pin;
            sync_p1 <= sync_p0;
            // A good stop bit counts as the level preceding the next start bit,
            // so a start arriving mid-stop is still seen as a falling edge.
            rx_p2   <= load_byte ? 1'b1 : sync_p1;
            settle  <= {settle[1:0], 1'b1};

            if (restart)
                os_cnt <= '0;
            else if (tick)
                os_cnt <= os_cnt + 4'd1;

            if (state == START && decide)
                bit_idx <= '0;
            else if (state == DATA && decide)
                bit_idx <= bit_idx + 3'd1;

            if (restart)
                par_err <= 1'b0;
            else if (state == PARITY && decide)
                par_err <= bit_val ^ (^shift_p) ^ (PARITY_ODD != 0);

            o_rx_over       <= load_byte;
            o_rx_parity_err <= load_byte & par_err;
            o_rx_frame_err  <= frame_bad;
            if (load_byte)
                o_rx_dat <= shift_p;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (tick && os_cnt == 4'd6)
            samp[0] <= sync_p1;
        if (tick && os_cnt == 4'd7)
            samp[1] <= sync_p1;
        if (state == DATA && decide)
            shift_p <= {bit_val, shift_p[DATA_W-1:1]};
    end

    assign o_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_rs232_byte_rx.sv
// Scoreboard bench for rs232_byte_rx: an 8N1 instance and an 8E1 instance,
// 32 clocks per bit, directed frames with hand-computed expectations.
module tb_rs232_byte_rx;

    localparam int CLK_FREQ = 32_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int BIT_CLKS = 32;

    typedef struct packed {
        logic       over;
        logic       ferr;
        logic       perr;
        logic [7:0] dat;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_n, line_p;
    logic [7:0] n_dat, p_dat;
    logic       n_over, n_ferr, n_perr, n_busy;
    logic       p_over, p_ferr, p_perr, p_busy;

    evt_t       q_n[$];
    evt_t       q_p[$];
    logic [7:0] held_n = 8'h00;
    logic [7:0] held_p = 8'h00;
    logic [1:0] prev_pulse = 2'b00;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    rs232_byte_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_n (
        .clk_ref(clk), .rst_n(rst_n), .i_rx_pin(line_n), .o_rx_dat(n_dat),
        .o_rx_over(n_over), .o_rx_frame_err(n_ferr), .o_rx_parity_err(n_perr),
        .o_rx_busy(n_busy)
    );

    rs232_byte_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clk_ref(clk), .rst_n(rst_n), .i_rx_pin(line_p), .o_rx_dat(p_dat),
        .o_rx_over(p_over), .o_rx_frame_err(p_ferr), .o_rx_parity_err(p_perr),
        .o_rx_busy(p_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int ch, input logic over, input logic ferr,
                            input logic perr, input logic [7:0] dat);
        evt_t act, exp;
        logic pulse;
        act   = {over, ferr, perr, dat};
        pulse = over | ferr | perr;
        if (pulse) begin
            check($sformatf("pulse_width_ch%0d", ch), {31'd0, prev_pulse[ch]}, 32'd0);
            if ((ch == 0 && q_n.size() == 0) || (ch == 1 && q_p.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse_ch%0d actual=%0h required=none", ch, act);
            end else begin
                if (ch == 0) exp = q_n.pop_front();
                else         exp = q_p.pop_front();
                check($sformatf("event_ch%0d", ch), 32'(act), 32'(exp));
            end
        end
        prev_pulse[ch] = pulse;
    endtask

    always @(negedge clk) begin
        mon_step(0, n_over, n_ferr, n_perr, n_dat);
        mon_step(1, p_over, p_ferr, p_perr, p_dat);
    end

    task automatic drive(input int ch, input logic v, input int n);
        if (ch == 0) line_n = v;
        else         line_p = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [7:0] b, input logic par_en,
                        input logic par_bit, input logic stop_val, input int stop_len);
        drive(ch, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(ch, b[i], BIT_CLKS);
        if (par_en) drive(ch, par_bit, BIT_CLKS);
        drive(ch, stop_val, stop_len);
    endtask

    task automatic expect_byte(input int ch, input logic [7:0] dat, input logic perr);
        if (ch == 0) begin q_n.push_back({1'b1, 1'b0, perr, dat}); held_n = dat; end
        else         begin q_p.push_back({1'b1, 1'b0, perr, dat}); held_p = dat; end
    endtask

    task automatic expect_ferr(input int ch);
        if (ch == 0) q_n.push_back({1'b0, 1'b1, 1'b0, held_n});
        else         q_p.push_back({1'b0, 1'b1, 1'b0, held_p});
    endtask

    initial begin
        rst_n  = 1'b0;
        line_n = 1'b1;
        line_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_n", {23'd0, n_dat, n_over, n_ferr, n_perr, n_busy}, 32'd0);
        check("reset_state_p", {23'd0, p_dat, p_over, p_ferr, p_perr, p_busy}, 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b1, 10);

        // 8N1 frame 0x55
        expect_byte(0, 8'h55, 1'b0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        drive(0, 1'b1, 64);
        check("busy_after_frame", {31'd0, n_busy}, 32'd0);

        // Short low glitch: start bit rejected, no pulse
        drive(0, 1'b0, 8);
        drive(0, 1'b1, 2);
        check("glitch_busy_start", {31'd0, n_busy}, 32'd1);
        drive(0, 1'b1, 30);
        check("glitch_busy_done", {31'd0, n_busy}, 32'd0);

        // 0xA3 with low stop bit, line held low: frame error then BREAK
        expect_ferr(0);
        send(0, 8'hA3, 1'b0, 1'b0, 1'b0, BIT_CLKS);
        drive(0, 1'b0, 60);
        check("break_hold_busy", {31'd0, n_busy}, 32'd1);
        drive(0, 1'b0, 40);
        check("break_hold_busy_late", {31'd0, n_busy}, 32'd1);
        drive(0, 1'b1, 10);
        check("break_exit_busy", {31'd0, n_busy}, 32'd0);
        check("break_dat_held", {24'd0, n_dat}, 32'h55);

        // Even parity: 0x07 has odd weight so parity bit 1 is correct, 0 is wrong
        expect_byte(1, 8'h07, 1'b1);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, BIT_CLKS);
        drive(1, 1'b1, 40);
        expect_byte(1, 8'h07, 1'b0);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, BIT_CLKS);
        drive(1, 1'b1, 40);
        expect_byte(1, 8'h55, 1'b0);
        send(1, 8'h55, 1'b1, 1'b0, 1'b1, BIT_CLKS);
        drive(1, 1'b1, 40);

        // Back-to-back with a half-length stop bit on the first byte
        expect_byte(0, 8'h00, 1'b0);
        expect_byte(0, 8'hFF, 1'b0);
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 16);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        drive(0, 1'b1, 64);

        // Reset during data bit 4 of 0x3C abandons the frame; transmitter goes idle
        drive(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(0, 1'(8'h3C >> i), BIT_CLKS);
        drive(0, 1'b1, 10);
        rst_n = 1'b0;
        drive(0, 1'b1, 4);
        check("midframe_reset_n", {23'd0, n_dat, n_over, n_ferr, n_perr, n_busy}, 32'd0);
        rst_n  = 1'b1;
        held_n = 8'h00;
        held_p = 8'h00;
        drive(0, 1'b1, 100);
        check("post_reset_idle", {31'd0, n_busy}, 32'd0);
        expect_byte(0, 8'h81, 1'b0);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        drive(0, 1'b1, 64);

        check("pending_n", 32'(q_n.size()), 32'd0);
        check("pending_p", 32'(q_p.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
